// File: rtl/bus_transfer_seq.sv
// bus_transfer_seq: queued register-to-register transfer sequencer.
// Holds the bus select for SETTLE cycles, then pulses the destination load enable.
module bus_transfer_seq #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_src,
   input  logic [3:0]  req_dst,
   output logic [3:0]  gp_register_select,
   input  logic [31:0] BusMuxOut,
   output logic [15:0] load_en,
   output logic        busy,
   output logic        done,
   output logic [3:0]  done_dst,
   output logic [31:0] done_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      LOAD
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_d;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          empty;
   logic [7:0]    head;

   logic [3:0]    sel_d;
   logic [3:0]    dst_q;
   logic [3:0]    dst_d;
   logic [15:0]   load_d;
   logic          fin;

   assign empty     = (count == '0);
   assign req_ready = (count < CW'(DEPTH));
   assign push      = req_valid && req_ready && !clear;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {req_src, req_dst};
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Popping from IDLE and from LOAD share one path so queued work runs gap-free.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      pop     = 1'b0;
      sel_d   = gp_register_select;
      dst_d   = dst_q;
      load_d  = '0;
      fin     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               sel_d   = head[7:4];
               dst_d   = head[3:0];
               cnt_d   = TW'(SETTLE - 1);
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt == '0) begin
               load_d  = 16'(1) << dst_q;
               state_d = LOAD;
            end else begin
               cnt_d = cnt - TW'(1);
            end
         end
         LOAD: begin
            fin = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               sel_d   = head[7:4];
               dst_d   = head[3:0];
               cnt_d   = TW'(SETTLE - 1);
               state_d = DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         gp_register_select <= '0;
         dst_q              <= '0;
         load_en            <= '0;
         done               <= 1'b0;
         done_dst           <= '0;
         done_data          <= '0;
      end else begin
         gp_register_select <= sel_d;
         dst_q              <= dst_d;
         load_en            <= load_d;
         done               <= fin;
         if (fin) begin
            done_dst  <= dst_q;
            done_data <= BusMuxOut;
         end
      end
   end

endmodule

// File: tb/tb_bus_transfer_seq.sv
// tb_bus_transfer_seq: three instances (SETTLE=1,2,3) against a schedule model.
// Directed tables/sequences plus randomized traffic with occasional clears.
module tb_bus_transfer_seq;
   localparam int N     = 3;
   localparam int DEPTH = 4;
   localparam int QN    = 64;

   logic        clock = 1'b0;
   logic        clear;
   logic        req_valid;
   logic [3:0]  req_src;
   logic [3:0]  req_dst;
   logic [31:0] regs [16];

   logic        req_ready [N];
   logic [3:0]  sel [N];
   logic [31:0] bus [N];
   logic [15:0] load_en [N];
   logic        busy [N];
   logic        done [N];
   logic [3:0]  done_dst [N];
   logic [31:0] done_data [N];

   always #5 clock = ~clock;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      assign bus[gi] = regs[sel[gi]];
      bus_transfer_seq #(.DEPTH(DEPTH), .SETTLE(gi + 1)) u_dut (
         .clock              (clock),
         .clear              (clear),
         .req_valid          (req_valid),
         .req_ready          (req_ready[gi]),
         .req_src            (req_src),
         .req_dst            (req_dst),
         .gp_register_select (sel[gi]),
         .BusMuxOut          (bus[gi]),
         .load_en            (load_en[gi]),
         .busy               (busy[gi]),
         .done               (done[gi]),
         .done_dst           (done_dst[gi]),
         .done_data          (done_data[gi])
      );
   end

   // Model: each accepted transfer gets its LOAD cycle computed at accept time.
   logic [3:0]  q_src [N][QN];
   logic [3:0]  q_dst [N][QN];
   int          q_load [N][QN];
   int          hd [N];
   int          tl [N];
   int          prev_load [N];
   logic [3:0]  m_sel [N];
   logic [3:0]  m_dst [N];
   logic [31:0] m_data [N];
   logic        m_ready [N];

   int cyc;
   int n_tests;
   int n_fail;

   typedef struct {
      logic        v;
      logic [3:0]  src;
      logic [3:0]  dst;
      logic [3:0]  sel;
      logic [15:0] le;
      logic        dn;
      logic [3:0]  ddst;
      logic [31:0] ddata;
   } vec_t;

   vec_t        tbl [6];
   logic [3:0]  bs [3];
   logic [3:0]  bd [3];
   int          lc [3];
   logic [15:0] lv [3];
   int          nl, nd, gap, base, pushed, got, full_at;
   int          lcyc, dcyc;
   logic [15:0] lval;
   logic [3:0]  gotd [8];
   logic        saw_full, acc_now;

   task automatic chk(input string name, input int i,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d cyc=%0d got=%h want=%h",
                  name, i, cyc, act, exp);
      end
   endtask

   task automatic sample();
      int s, occ, f;
      logic ed, eb;
      logic [15:0] ele;
      logic [3:0] esel;
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
         s = i + 1; ed = 1'b0; eb = 1'b0; occ = 0; ele = '0;
         while (hd[i] != tl[i] && q_load[i][hd[i] % QN] < cyc) begin
            f = hd[i] % QN;
            m_sel[i]  = q_src[i][f];
            m_dst[i]  = q_dst[i][f];
            m_data[i] = regs[q_src[i][f]];
            if (q_load[i][f] == cyc - 1) ed = 1'b1;
            hd[i]++;
         end
         esel = m_sel[i];
         if (hd[i] != tl[i]) begin
            f = hd[i] % QN;
            if (cyc >= q_load[i][f] - s) begin
               eb = 1'b1;
               esel = q_src[i][f];
            end
            if (q_load[i][f] == cyc) ele = 16'(1) << q_dst[i][f];
         end
         for (int k = hd[i]; k < tl[i]; k++)
            if (q_load[i][k % QN] - s - 1 >= cyc) occ++;
         if (occ > 0) eb = 1'b1;
         m_ready[i] = (occ < DEPTH);
         chk("sel", i, 32'(sel[i]), 32'(esel));
         chk("load_en", i, 32'(load_en[i]), 32'(ele));
         chk("done", i, 32'(done[i]), 32'(ed));
         chk("done_dst", i, 32'(done_dst[i]), 32'(m_dst[i]));
         chk("done_data", i, done_data[i], m_data[i]);
         chk("busy", i, 32'(busy[i]), 32'(eb));
         chk("req_ready", i, 32'(req_ready[i]), 32'(m_ready[i]));
      end
   endtask

   task automatic advance();
      int s, ld, f;
      @(posedge clock);
      for (int i = 0; i < N; i++) begin
         s = i + 1;
         if (clear) begin
            hd[i] = tl[i];
            prev_load[i] = -1000;
            m_sel[i] = '0;
            m_dst[i] = '0;
            m_data[i] = '0;
         end else if (req_valid && m_ready[i]) begin
            ld = cyc + s + 2;
            if (prev_load[i] + s + 1 > ld) ld = prev_load[i] + s + 1;
            f = tl[i] % QN;
            q_src[i][f] = req_src;
            q_dst[i][f] = req_dst;
            q_load[i][f] = ld;
            tl[i]++;
            prev_load[i] = ld;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic drain();
      logic any;
      req_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         cycle();
         any = 1'b0;
         for (int i = 0; i < N; i++) if (hd[i] != tl[i]) any = 1'b1;
         if (!any) break;
      end
      cycle();
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      clear = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0;
      for (int k = 0; k < 16; k++) regs[k] = $urandom;
      for (int i = 0; i < N; i++) begin
         hd[i] = 0; tl[i] = 0; prev_load[i] = -1000;
         m_sel[i] = '0; m_dst[i] = '0; m_data[i] = '0; m_ready[i] = 1'b1;
      end
      @(posedge clock);
      #1;
      cycle();
      cycle();
      clear = 1'b0;

      // single transfer on the SETTLE=1 instance
      regs[3] = 32'hDEAD_BEEF;
      tbl[0] = '{1'b1, 4'd3, 4'd7, 4'd0, 16'h0000, 1'b0, 4'd0, 32'h0};
      tbl[1] = '{1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 4'd0, 32'h0};
      tbl[2] = '{1'b0, 4'd0, 4'd0, 4'd3, 16'h0000, 1'b0, 4'd0, 32'h0};
      tbl[3] = '{1'b0, 4'd0, 4'd0, 4'd3, 16'h0080, 1'b0, 4'd0, 32'h0};
      tbl[4] = '{1'b0, 4'd0, 4'd0, 4'd3, 16'h0000, 1'b1, 4'd7, 32'hDEAD_BEEF};
      tbl[5] = '{1'b0, 4'd0, 4'd0, 4'd3, 16'h0000, 1'b0, 4'd7, 32'hDEAD_BEEF};
      for (int k = 0; k < 6; k++) begin
         req_valid = tbl[k].v; req_src = tbl[k].src; req_dst = tbl[k].dst;
         sample();
         chk("t_sel", 0, 32'(sel[0]), 32'(tbl[k].sel));
         chk("t_load_en", 0, 32'(load_en[0]), 32'(tbl[k].le));
         chk("t_done", 0, 32'(done[0]), 32'(tbl[k].dn));
         chk("t_done_dst", 0, 32'(done_dst[0]), 32'(tbl[k].ddst));
         chk("t_done_data", 0, done_data[0], tbl[k].ddata);
         advance();
      end
      drain();

      // back-to-back on SETTLE=2
      bs = '{4'd1, 4'd4, 4'd6};
      bd = '{4'd2, 4'd5, 4'd0};
      nl = 0; nd = 0; gap = 0; base = cyc;
      for (int k = 0; k < 14; k++) begin
         req_valid = (k < 3);
         req_src = (k < 3) ? bs[k] : 4'd0;
         req_dst = (k < 3) ? bd[k] : 4'd0;
         sample();
         if (load_en[1] != 16'h0) begin
            if (nl < 3) begin lc[nl] = cyc - base; lv[nl] = load_en[1]; end
            nl++;
         end
         if (done[1]) nd++;
         if (k >= 1 && k <= 10 && !busy[1]) gap++;
         advance();
      end
      chk("b2b_nloads", 1, 32'(nl), 32'd3);
      chk("b2b_ndone", 1, 32'(nd), 32'd3);
      chk("b2b_gap", 1, 32'(gap), 32'd0);
      chk("b2b_load0", 1, 32'(lc[0]), 32'd4);
      chk("b2b_load1", 1, 32'(lc[1]), 32'd7);
      chk("b2b_load2", 1, 32'(lc[2]), 32'd10);
      chk("b2b_le0", 1, 32'(lv[0]), 32'h0004);
      chk("b2b_le1", 1, 32'(lv[1]), 32'h0020);
      chk("b2b_le2", 1, 32'(lv[2]), 32'h0001);
      drain();

      // full FIFO on SETTLE=3
      pushed = 0; got = 0; saw_full = 1'b0; full_at = -1;
      for (int k = 0; k < 200 && got < 6; k++) begin
         req_valid = (pushed < 6);
         req_src = 4'(pushed);
         req_dst = 4'(pushed + 9);
         sample();
         acc_now = req_valid && req_ready[2];
         if (!req_ready[2] && !saw_full) begin
            saw_full = 1'b1; full_at = pushed;
         end
         if (done[2]) begin
            if (got < 8) gotd[got] = done_dst[2];
            got++;
         end
         advance();
         if (acc_now) pushed++;
      end
      req_valid = 1'b0;
      chk("full_seen", 2, 32'(saw_full), 32'd1);
      chk("full_at", 2, 32'(full_at), 32'd5);
      chk("full_ndone", 2, 32'(got), 32'd6);
      for (int k = 0; k < 6; k++)
         chk("full_order", 2, 32'(gotd[k]), 32'(k + 9));
      drain();

      // push in the LOAD cycle at occupancy 1, SETTLE=1
      bs = '{4'd2, 4'd5, 4'd9};
      bd = '{4'd3, 4'd6, 4'd10};
      nl = 0; nd = 0; gap = 0; base = cyc;
      for (int k = 0; k < 10; k++) begin
         req_valid = (k == 0 || k == 1 || k == 3);
         req_src = (k == 3) ? bs[2] : bs[k % 2];
         req_dst = (k == 3) ? bd[2] : bd[k % 2];
         sample();
         if (k == 3) chk("pp_ready", 0, 32'(req_ready[0]), 32'd1);
         if (load_en[0] != 16'h0) begin
            if (nl < 3) begin lc[nl] = cyc - base; lv[nl] = load_en[0]; end
            nl++;
         end
         if (done[0]) nd++;
         if (k >= 1 && k <= 7 && !busy[0]) gap++;
         advance();
      end
      chk("pp_nloads", 0, 32'(nl), 32'd3);
      chk("pp_ndone", 0, 32'(nd), 32'd3);
      chk("pp_gap", 0, 32'(gap), 32'd0);
      chk("pp_load0", 0, 32'(lc[0]), 32'd3);
      chk("pp_load1", 0, 32'(lc[1]), 32'd5);
      chk("pp_load2", 0, 32'(lc[2]), 32'd7);
      chk("pp_le2", 0, 32'(lv[2]), 32'h0400);
      drain();

      // clear mid-DRIVE with two queued, SETTLE=3; request in clear cycle dropped
      for (int k = 0; k < 4; k++) begin
         req_valid = 1'b1;
         req_src = 4'(k + 1);
         req_dst = 4'(k + 4);
         clear = (k == 3);
         sample();
         advance();
      end
      clear = 1'b0; req_valid = 1'b0;
      sample();
      chk("clr_load_en", 2, 32'(load_en[2]), 32'h0);
      chk("clr_done", 2, 32'(done[2]), 32'd0);
      chk("clr_busy", 2, 32'(busy[2]), 32'd0);
      chk("clr_ready", 2, 32'(req_ready[2]), 32'd1);
      chk("clr_sel", 2, 32'(sel[2]), 32'd0);
      advance();
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         sample();
         if (done[2]) nd++;
         advance();
      end
      chk("clr_nodone", 2, 32'(nd), 32'd0);
      lcyc = -1; dcyc = -1; lval = '0; base = cyc;
      for (int k = 0; k < 10; k++) begin
         req_valid = (k == 0); req_src = 4'd7; req_dst = 4'd11;
         sample();
         if (load_en[2] != 16'h0 && lcyc < 0) begin
            lcyc = cyc - base; lval = load_en[2];
         end
         if (done[2] && dcyc < 0) dcyc = cyc - base;
         advance();
      end
      chk("post_clr_load", 2, 32'(lcyc), 32'd5);
      chk("post_clr_le", 2, 32'(lval), 32'h0800);
      chk("post_clr_done", 2, 32'(dcyc), 32'd6);
      chk("post_clr_dst", 2, 32'(done_dst[2]), 32'd11);
      drain();

      // src == dst == 15
      regs[15] = 32'h0000_0001;
      lcyc = -1; dcyc = -1; lval = '0; base = cyc;
      for (int k = 0; k < 6; k++) begin
         req_valid = (k == 0); req_src = 4'd15; req_dst = 4'd15;
         sample();
         if (load_en[0] != 16'h0 && lcyc < 0) begin
            lcyc = cyc - base; lval = load_en[0];
         end
         if (done[0] && dcyc < 0) dcyc = cyc - base;
         advance();
      end
      chk("self_load", 0, 32'(lcyc), 32'd3);
      chk("self_le", 0, 32'(lval), 32'h8000);
      chk("self_done", 0, 32'(dcyc), 32'd4);
      chk("self_data", 0, done_data[0], 32'h1);
      drain();

      // random traffic
      for (int k = 0; k < 16; k++) regs[k] = $urandom;
      for (int k = 0; k < 1500; k++) begin
         req_valid = ($urandom_range(0, 99) < 60);
         req_src = 4'($urandom_range(0, 15));
         req_dst = 4'($urandom_range(0, 15));
         clear = ($urandom_range(0, 199) == 0);
         cycle();
      end
      clear = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
